// File: rtl/pit_counter_channel.sv
// One programmable-interval-timer counter channel: modes 0-3, gate edge
// triggering, count latching and a null-count flag. CE value 0 stands for 2^WIDTH.
module pit_counter_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             load,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] count_in,
  input  logic             gate,
  input  logic             latch,
  output logic             out,
  output logic [WIDTH-1:0] count_out,
  output logic [WIDTH-1:0] latched_out,
  output logic             null_count
);

  typedef enum logic [1:0] {IDLE, LOADING, WAIT_TRIG, COUNTING} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cr_reg;
  logic [WIDTH-1:0] ce_reg, ce_next;
  logic [WIDTH-1:0] latched_reg;
  logic [1:0]       mode_reg;
  logic             out_reg, out_next;
  logic             null_reg, null_next;
  logic             gate_q;

  logic             write;
  logic             rise;
  logic [WIDTH:0]   n_eff;
  logic [WIDTH-1:0] n_load;
  logic [WIDTH-1:0] half_lo;
  logic [WIDTH-1:0] half_hi;

  assign write = cs & load;
  assign rise  = gate & ~gate_q;

  // Effective reload value: 0 means 2^WIDTH; modes 2/3 promote an illegal 1 to 2.
  always_comb begin
    if (cr_reg == '0)
      n_eff = {1'b1, {WIDTH{1'b0}}};
    else if (mode_reg[1] && cr_reg == WIDTH'(1))
      n_eff = (WIDTH+1)'(2);
    else
      n_eff = {1'b0, cr_reg};
  end

  assign n_load  = n_eff[WIDTH-1:0];
  assign half_lo = n_eff[WIDTH:1];
  assign half_hi = half_lo + WIDTH'(n_eff[0]);

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cr_reg      <= '0;
      ce_reg      <= '0;
      mode_reg    <= 2'd0;
      out_reg     <= 1'b0;
      null_reg    <= 1'b1;
      latched_reg <= '0;
      gate_q      <= 1'b0;
    end else begin
      gate_q   <= gate;
      ce_reg   <= ce_next;
      out_reg  <= out_next;
      null_reg <= null_next;
      if (cs && latch)
        latched_reg <= ce_reg;
      if (write) begin
        cr_reg   <= count_in;
        mode_reg <= mode_in;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ce_next    = ce_reg;
    out_next   = out_reg;
    null_next  = null_reg;
    if (write) begin
      null_next  = 1'b1;
      out_next   = (mode_in != 2'd0);
      state_next = (mode_in == 2'd1) ? WAIT_TRIG : LOADING;
    end else begin
      unique case (state_reg)
        LOADING: begin
          if (mode_reg == 2'd0 || gate) begin
            ce_next    = (mode_reg == 2'd3) ? half_hi : n_load;
            null_next  = 1'b0;
            state_next = COUNTING;
            if (mode_reg == 2'd3)
              out_next = 1'b1;
          end
        end
        WAIT_TRIG: begin
          if (rise) begin
            ce_next    = n_load;
            out_next   = 1'b0;
            null_next  = 1'b0;
            state_next = COUNTING;
          end
        end
        COUNTING: begin
          unique case (mode_reg)
            2'd0: begin
              if (gate) begin
                ce_next = ce_reg - WIDTH'(1);
                if (ce_reg == WIDTH'(1))
                  out_next = 1'b1;
              end
            end
            2'd1: begin
              if (rise) begin
                ce_next = n_load;
              end else begin
                ce_next = ce_reg - WIDTH'(1);
                if (ce_reg == WIDTH'(1)) begin
                  out_next   = 1'b1;
                  state_next = WAIT_TRIG;
                end
              end
            end
            2'd2: begin
              if (!gate) begin
                out_next   = 1'b1;
                state_next = LOADING;
              end else if (ce_reg == WIDTH'(2)) begin
                ce_next  = WIDTH'(1);
                out_next = 1'b0;
              end else if (ce_reg == WIDTH'(1)) begin
                ce_next  = n_load;
                out_next = 1'b1;
              end else begin
                ce_next = ce_reg - WIDTH'(1);
              end
            end
            default: begin
              // Square wave: the low half gets floor(N/2), the high half ceil(N/2).
              if (!gate) begin
                out_next   = 1'b1;
                state_next = LOADING;
              end else if (ce_reg == WIDTH'(1)) begin
                out_next = ~out_reg;
                ce_next  = out_reg ? half_lo : half_hi;
              end else begin
                ce_next = ce_reg - WIDTH'(1);
              end
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    out         = out_reg;
    count_out   = ce_reg;
    latched_out = latched_reg;
    null_count  = null_reg;
  end

endmodule

// File: doc/pit_counter_channel.md
# pit_counter_channel

- Parametrised programmable-interval-timer counter channel; next generation of the mode-0 counter.
- Adds configurable width, four counting modes, gate-edge triggering, count latching and a null-count flag:
  - mode 0: interrupt on terminal count
  - mode 1: hardware one-shot
  - mode 2: rate generator
  - mode 3: square wave
- One instance per timer channel; the control-word decoder drives `load`/`latch` strobes from CPU writes.

## Interface
- `WIDTH`, default 16: counter width in bits. Count value 0 encodes 2^WIDTH.
- `clk` input, 1 bit: clock; also the counting clock (one decrement per enabled edge).
- `rst` input, 1 bit: synchronous, active-high reset.
- `cs` input, 1 bit: chip select, active high. When low, `load` and `latch` are ignored; counting continues.
- `load` input, 1 bit: one-cycle strobe; writes `count_in` and `mode_in`.
- `mode_in` input, 2 bits: counting mode 0–3.
- `count_in` input, WIDTH bits: initial count N.
- `gate` input, 1 bit: gate; registered internally into `gate_q` for edge detection.
- `latch` input, 1 bit: one-cycle strobe; snapshots the counting element.
- `out` output, 1 bit: timer output.
- `count_out` output, WIDTH bits: live counting element CE.
- `latched_out` output, WIDTH bits: last latched CE value.
- `null_count` output, 1 bit: high from a write until CR has been transferred to CE.

## Operation
- Registers:
  - CR: count register
  - CE: counting element
  - MODE
  - `gate_q`
  - `latched_out`
  - FSM state: IDLE, LOADING, WAIT_TRIG, COUNTING
- Reset (rst=1 at edge):
  - CR=0, CE=0, MODE=0
  - out=0, null_count=1, latched_out=0, `gate_q`=0
  - state IDLE
  - rst overrides every other input.
- Write (`cs&load`):
  - CR<=`count_in`, MODE<=`mode_in`, null_count<=1; any count in progress is aborted.
  - out<=0 for mode 0; out<=1 for modes 1–3.
  - Next state: WAIT_TRIG for mode 1, LOADING otherwise.
- Effective count: N=0 means 2^WIDTH. In modes 2/3, N=1 is illegal and is treated as 2.
- Gate rising edge (`rise`): `gate & ~gate_q`.
- LOADING:
  - Modes 0, 2: CE<=N, null_count<=0, go to COUNTING. Modes 2/3 require gate=1; otherwise stay in LOADING.
  - Mode 0 loads regardless of gate.
  - Mode 3: CE<=ceil(N/2), out<=1.
- WAIT_TRIG (mode 1): on `rise`, CE<=N, out<=0, null_count<=0, go to COUNTING.
- COUNTING, mode 0:
  - If gate=1, CE<=CE-1; CE holds while gate=0.
  - On the decrement 1→0, out<=1.
  - Afterwards CE keeps decrementing (wraps from 0 to 2^WIDTH-1) while out stays 1 until the next write.
- COUNTING, mode 1:
  - CE decrements every edge regardless of gate level.
  - On 1→0, out<=1, state WAIT_TRIG.
  - `rise` while counting retriggers: CE<=N, out stays 0.
- COUNTING, mode 2:
  - gate=0: out<=1, CE holds, state LOADING.
  - CE==2: CE<=1, out<=0.
  - CE==1: CE<=N, out<=1.
  - Otherwise CE<=CE-1.
- COUNTING, mode 3:
  - gate=0: out<=1, CE holds, state LOADING.
  - CE==1: out<=~out; CE<=floor(N/2) when going low, ceil(N/2) when going high.
  - Otherwise CE<=CE-1.
- Latch: `cs&latch` sets latched_out<=CE, using CE's value before this edge's update.
- All arithmetic is modulo 2^WIDTH. ceil/floor of N=2^WIDTH is 2^(WIDTH-1).

## Timing
- Write at edge k (mode 0/2/3, gate=1):
  - CE=N and null_count=0 at edge k+1.
  - First decrement at edge k+2.
- Mode 0, gate held high: out rises at edge k+1+N.
- Mode 1, `rise` sampled at edge t: out=0 from t, out=1 at edge t+N.
- Mode 2: period N clocks, out low for exactly 1 clock. First low at edge k+N.
- Mode 3:
  - out high ceil(N/2) clocks, low floor(N/2) clocks.
  - N=3: 2 high/1 low. N=1: 1 high/1 low.
- Gate low in mode 2/3 takes effect at the next edge. Gate re-high causes reload one edge later (LOADING→COUNTING).
- Simultaneous write and latch: latch captures old CE; write proceeds.
- Write during rst: ignored.

## Test plan
- Reset, then `cs`=1, `load`, mode 0, N=5, gate=1:
  - out=0 until edge k+6, then 1.
  - null_count falls at k+1.
- Mode 0, N=4, gate low for 3 cycles mid-count: out rise delayed by exactly 3 clocks.
- Mode 1, N=3:
  - `rise` at t gives out low t..t+2, high at t+3.
  - A second `rise` at t+1 extends the low period to end at t+4.
- Mode 2, N=4: out pattern 1,1,1,0 repeating. Gate dropped mid-period forces out=1, then restarts a full period after gate returns.
- Mode 3 square wave: N=5 gives 3 high/2 low; N=1 gives 1/1; N=0 with WIDTH=4 gives 8 high/8 low.
- Latch and `cs` gating:
  - latch with CE=7 gives latched_out=7 while CE keeps counting.
  - `load` with `cs`=0 changes nothing.
  - rst mid-count returns all outputs to their reset values.
